aes_key_sched_ctrl: RTL and testbench

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl_if.sv | 27 ++
 rtl/aes_key_sched_ctrl.sv | 125 ++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-schedule control bundle between a host/datapath and the key-schedule controller.
// Latency: none; this file holds wires only.
// Backpressure: sbox_req is held until the S-box answers with sbox_ack.
//
// master : host side; drives init/keylen/sbox_ack and observes the controls.
// slave  : controller side; drives sbox_req/rcon/use_rcon/round_ctr/key_we/ready.
interface aes_key_sched_ctrl_if;
  logic       init;
  logic       keylen;
  logic       sbox_ack;
  logic       sbox_req;
  logic [7:0] rcon;
  logic       use_rcon;
  logic [3:0] round_ctr;
  logic       key_we;
  logic       ready;

  modport master (
    output init, keylen, sbox_ack,
    input  sbox_req, rcon, use_rcon, round_ctr, key_we, ready
  );

  modport slave (
    input  init, keylen, sbox_ack,
    output sbox_req, rcon, use_rcon, round_ctr, key_we, ready
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128/256 key-expansion sequencer: orders round-key writes, SubWord requests and rcon.
// Latency: ready returns 22 (AES-128) / 29 (AES-256) edges after init, plus one per S-box wait cycle.
// Backpressure: stalls in SUB with sbox_req high until sbox_ack; nothing else can stall it.
//
// Ports: clk, reset_n (async, active low) and ks (slave modport):
//   in : init, keylen (0=AES-128, 1=AES-256), sbox_ack
//   out: sbox_req, rcon[7:0], use_rcon, round_ctr[3:0], key_we, ready
module aes_key_sched_ctrl #(
  parameter logic [7:0] RCON_INIT = 8'h8d
) (
  input  logic                 clk,
  input  logic                 reset_n,
  aes_key_sched_ctrl_if.slave  ks
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT0 = 3'd1,
    INIT1 = 3'd2,
    SUB   = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state;
  logic       keylen_reg;
  logic [3:0] round_ctr;
  logic [7:0] rcon;
  logic       ready_q;
  logic       key_we_q;
  logic       sbox_req_q;

  logic [7:0] rcon_next;
  logic [3:0] last_round;
  logic [3:0] round_inc;
  logic       inc_uses_rcon;

  // GF(2^8) multiply-by-x; RCON_INIT is chosen so the first step yields 8'h01.
  assign rcon_next     = {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});
  assign last_round    = keylen_reg ? 4'd14 : 4'd10;
  assign round_inc     = round_ctr + 4'd1;
  // AES-256 alternates: even rounds RotWord+rcon, odd rounds SubWord only.
  assign inc_uses_rcon = ~keylen_reg | ~round_inc[0];

  // Outputs are registered alongside the state so each is a pure function of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      keylen_reg <= 1'b0;
      round_ctr  <= 4'd0;
      rcon       <= 8'h00;
      ready_q    <= 1'b1;
      key_we_q   <= 1'b0;
      sbox_req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ks.init) begin
            keylen_reg <= ks.keylen;
            round_ctr  <= 4'd0;
            rcon       <= RCON_INIT;
            state      <= INIT0;
            ready_q    <= 1'b0;
            key_we_q   <= 1'b1;
          end
        end
        INIT0: begin
          // Round key 0 is the raw key; AES-256 also writes key word-set 1 raw.
          round_ctr <= 4'd1;
          if (keylen_reg) begin
            state    <= INIT1;
            key_we_q <= 1'b1;
          end else begin
            rcon       <= rcon_next;
            state      <= SUB;
            key_we_q   <= 1'b0;
            sbox_req_q <= 1'b1;
          end
        end
        INIT1: begin
          round_ctr  <= 4'd2;
          rcon       <= rcon_next;
          state      <= SUB;
          key_we_q   <= 1'b0;
          sbox_req_q <= 1'b1;
        end
        SUB: begin
          if (ks.sbox_ack) begin
            state      <= WRITE;
            sbox_req_q <= 1'b0;
            key_we_q   <= 1'b1;
          end
        end
        WRITE: begin
          key_we_q <= 1'b0;
          if (round_ctr == last_round) begin
            // round_ctr and rcon are left at their final values.
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            round_ctr  <= round_inc;
            if (inc_uses_rcon) begin
              rcon <= rcon_next;
            end
            state      <= SUB;
            sbox_req_q <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          ready_q    <= 1'b1;
          key_we_q   <= 1'b0;
          sbox_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign ks.ready     = ready_q;
  assign ks.key_we    = key_we_q;
  assign ks.sbox_req  = sbox_req_q;
  assign ks.round_ctr = round_ctr;
  assign ks.rcon      = rcon;
  assign ks.use_rcon  = ~keylen_reg | ~round_ctr[0];

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: directed runs plus random S-box delays and input noise,
// checked against a round-level model of the AES key schedule (rcon table, strobe order, latency).
module tb_aes_key_sched_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   dly[16];

  aes_key_sched_ctrl_if bus();

  aes_key_sched_ctrl #(.RCON_INIT(8'h8d)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ks      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // AES round constants: rcon_i = x^(i-1) in GF(2^8).
  function automatic logic [7:0] model_rcon(input bit kl, input int r);
    logic [7:0] tab[10];
    int idx;
    tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    idx = kl ? (r / 2 - 1) : (r - 1);
    if (idx < 0) idx = 0;
    return tab[idx];
  endfunction

  function automatic bit model_use_rcon(input bit kl, input int r);
    return kl ? ((r % 2) == 0) : 1'b1;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_ready"},    32'(bus.ready),     32'd1);
    chk({pfx, "_key_we"},   32'(bus.key_we),    32'd0);
    chk({pfx, "_sbox_req"}, 32'(bus.sbox_req),  32'd0);
    chk({pfx, "_use_rcon"}, 32'(bus.use_rcon),  32'd1);
    chk({pfx, "_round"},    32'(bus.round_ctr), 32'd0);
    chk({pfx, "_rcon"},     32'(bus.rcon),      32'd0);
  endtask

  // One full expansion. Must be entered just after a falling edge with the DUT idle.
  // tied: sbox_ack constantly 1; otherwise ack comes after dly[round] SUB cycles.
  // noise: random init/keylen mid-run and random sbox_ack outside SUB.
  // abort_round != 0: drop reset mid-cycle in that round's SUB, then stop.
  task automatic run_exp(input bit kl, input bit tied, input bit noise, input int abort_round);
    int  last_r, first_sub, exp_lat, exp_idx, sub_cnt, cycles, c;
    bit  done, aborted;
    last_r    = kl ? 14 : 10;
    first_sub = kl ? 2 : 1;
    exp_lat   = kl ? 29 : 22;
    for (int r = first_sub; r <= last_r; r++) exp_lat += tied ? 0 : dly[r];
    exp_idx = 0; sub_cnt = 0; cycles = 0; c = 0; done = 0; aborted = 0;

    chk("start_ready", 32'(bus.ready), 32'd1);
    bus.init     = 1'b1;
    bus.keylen   = kl;
    bus.sbox_ack = tied ? 1'b1 : (noise ? 1'($urandom % 2) : 1'b0);

    while (!done && !aborted && c < 400) begin
      @(negedge clk);
      c++;
      chk("mutex", 32'(bus.key_we & bus.sbox_req), 32'd0);
      if (bus.ready) begin
        done   = 1;
        cycles = c;
        bus.init = 1'b0;
      end else begin
        if (bus.key_we) begin
          chk("strobe_idx", 32'(bus.round_ctr), 32'(exp_idx));
          if (exp_idx >= first_sub)
            chk("sub_len", 32'(sub_cnt), 32'(tied ? 1 : dly[exp_idx] + 1));
          exp_idx++;
          sub_cnt = 0;
        end
        if (bus.sbox_req) begin
          chk("sub_round", 32'(bus.round_ctr), 32'(exp_idx));
          chk("sub_rcon",  32'(bus.rcon),      32'(model_rcon(kl, exp_idx)));
          chk("sub_use",   32'(bus.use_rcon),  32'(model_use_rcon(kl, exp_idx)));
          if (abort_round != 0 && exp_idx == abort_round) begin
            #2;
            reset_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            for (int k = 0; k < 3; k++) begin
              @(negedge clk);
              chk("abort_no_we", 32'(bus.key_we), 32'd0);
              chk("abort_ready", 32'(bus.ready),  32'd1);
            end
            reset_n = 1'b1;
            aborted = 1;
          end else begin
            bus.sbox_ack = tied ? 1'b1 : (sub_cnt >= dly[exp_idx]);
            sub_cnt++;
          end
        end else begin
          bus.sbox_ack = tied ? 1'b1 : (noise ? 1'($urandom % 2) : 1'b0);
        end
        if (!aborted) begin
          bus.init   = noise ? 1'($urandom % 2) : 1'b0;
          bus.keylen = 1'($urandom % 2);
        end
      end
    end

    if (!aborted) begin
      chk("latency",     32'(cycles),        32'(exp_lat));
      chk("strobes",     32'(exp_idx),       32'(last_r + 1));
      chk("final_round", 32'(bus.round_ctr), 32'(last_r));
      chk("final_rcon",  32'(bus.rcon),      32'(model_rcon(kl, last_r)));
      bus.init = 1'b0;
      bus.sbox_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("hold_ready", 32'(bus.ready),     32'd1);
        chk("hold_we",    32'(bus.key_we),    32'd0);
        chk("hold_req",   32'(bus.sbox_req),  32'd0);
        chk("hold_round", 32'(bus.round_ctr), 32'(last_r));
        chk("hold_rcon",  32'(bus.rcon),      32'(model_rcon(kl, last_r)));
      end
      bus.sbox_ack = 1'b0;
    end
  endtask

  initial begin
    reset_n      = 1'b1;
    bus.init     = 1'b0;
    bus.keylen   = 1'b0;
    bus.sbox_ack = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_no_init", 32'(bus.ready), 32'd1);

    for (int i = 0; i < 16; i++) dly[i] = 0;
    run_exp(1'b0, 1'b1, 1'b0, 0);          // AES-128, ack tied high
    run_exp(1'b1, 1'b1, 1'b0, 0);          // AES-256, ack tied high

    for (int i = 0; i < 16; i++) dly[i] = 3;
    run_exp(1'b0, 1'b0, 1'b0, 0);          // AES-128, ack 3 cycles late each round

    for (int i = 0; i < 16; i++) dly[i] = 0;
    run_exp(1'b0, 1'b0, 1'b1, 0);          // stray init/ack noise, immediate ack
    for (int i = 0; i < 16; i++) dly[i] = 2;
    run_exp(1'b1, 1'b0, 1'b1, 0);          // stray noise must not shorten SUB

    for (int i = 0; i < 16; i++) dly[i] = 0;
    run_exp(1'b0, 1'b1, 1'b0, 5);          // reset during round 5 SUB
    run_exp(1'b0, 1'b1, 1'b0, 0);          // clean restart afterwards

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) dly[i] = int'($urandom_range(0, 4));
      run_exp(1'($urandom % 2), 1'b0, 1'b1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
